// File: rtl/lut_layer_cfg.sv
// Runtime-reconfigurable layer of LUT neurons: serially loaded truth tables,
// a 2-stage valid/ready data pipeline and a load/drain configuration FSM.
module lut_layer_cfg #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned IN_BITS   = 6,
    parameter int unsigned OUT_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_start,
    input  logic                          cfg_valid,
    input  logic [OUT_BITS-1:0]           cfg_data,
    output logic                          cfg_done,
    output logic                          cfg_loaded,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS*OUT_BITS-1:0] out_data
);

    localparam int unsigned DEPTH = 1 << IN_BITS;
    localparam int unsigned TOTAL = N_NEURONS * DEPTH;
    localparam int unsigned AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    typedef enum logic [1:0] {UNLOADED, DRAIN, LOADING, READY} state_t;

    state_t                          state;
    logic [AW-1:0]                   addr;
    logic [OUT_BITS-1:0]             tbl [TOTAL];
    logic                            s1_valid;
    logic [N_NEURONS*IN_BITS-1:0]    s1_data;
    logic                            s2_free;
    logic                            tbl_we;
    logic [N_NEURONS*OUT_BITS-1:0]   lookup;

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = (state == READY) && (!s1_valid || s2_free);
    // cfg_start in LOADING wins over a same-cycle write
    assign tbl_we   = (state == LOADING) && cfg_valid && !cfg_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= UNLOADED;
            addr       <= '0;
            cfg_done   <= 1'b0;
            cfg_loaded <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            unique case (state)
                UNLOADED: begin
                    if (cfg_start) begin
                        state <= LOADING;
                        addr  <= '0;
                    end
                end
                READY: begin
                    if (cfg_start) state <= DRAIN;
                end
                DRAIN: begin
                    // empty after this edge: s1 idle and stage 2 idle or handing off
                    if (!s1_valid && s2_free) begin
                        state      <= LOADING;
                        addr       <= '0;
                        cfg_loaded <= 1'b0;
                    end
                end
                LOADING: begin
                    if (cfg_start) begin
                        addr <= '0;
                    end else if (cfg_valid) begin
                        if (addr == AW'(TOTAL - 1)) begin
                            state      <= READY;
                            addr       <= '0;
                            cfg_done   <= 1'b1;
                            cfg_loaded <= 1'b1;
                        end else begin
                            addr <= addr + AW'(1);
                        end
                    end
                end
                default: state <= UNLOADED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TOTAL; i++) tbl[i] <= '0;
        end else if (tbl_we) begin
            tbl[addr] <= cfg_data;
        end
    end

    always_comb begin
        lookup = '0;
        for (int unsigned k = 0; k < N_NEURONS; k++) begin
            lookup[k*OUT_BITS +: OUT_BITS] =
                tbl[AW'(k * DEPTH) + AW'(s1_data[k*IN_BITS +: IN_BITS])];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (in_valid && in_ready) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
            end else if (s2_free) begin
                s1_valid <= 1'b0;
            end
            if (s2_free) begin
                out_valid <= s1_valid;
                if (s1_valid) out_data <= lookup;
            end
        end
    end

endmodule

// File: tb/tb_lut_layer_cfg.sv
// Directed bench for lut_layer_cfg: table loads, lookups, backpressure,
// reload-while-busy, restart mid-load and reset mid-load.
module tb_lut_layer_cfg;

    localparam int unsigned N  = 4;
    localparam int unsigned IB = 6;
    localparam int unsigned OB = 1;
    localparam int unsigned TOTAL = N * (1 << IB);

    logic            clk;
    logic            rst_n;
    logic            cfg_start;
    logic            cfg_valid;
    logic [OB-1:0]   cfg_data;
    logic            cfg_done;
    logic            cfg_loaded;
    logic            in_valid;
    logic            in_ready;
    logic [N*IB-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [N*OB-1:0] out_data;

    int nvec = 0;
    int nmis = 0;

    logic [OB-1:0]   tbl_ref [TOTAL];
    logic [N*OB-1:0] sb [$];

    // hand-computed lookups under the identity table (neuron k returns bit k of its slice)
    logic [N*IB-1:0] vin    [6] = '{24'h000000, 24'h204081, 24'hDFBF7E, 24'hFFFFFF, 24'h004001, 24'h200080};
    logic [N*OB-1:0] exp_id [6] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h5, 4'hA};

    lut_layer_cfg #(.N_NEURONS(N), .IN_BITS(IB), .OUT_BITS(OB)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_done(cfg_done), .cfg_loaded(cfg_loaded),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OB-1:0] pat_val(input int pat, input int unsigned a);
        logic [IB-1:0] idx;
        idx = IB'(a % (1 << IB));
        case (pat)
            0:       return idx[(a / (1 << IB)) % IB];
            1:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [N*OB-1:0] ref_lookup(input logic [N*IB-1:0] d);
        logic [N*OB-1:0] r;
        logic [IB-1:0]   idx;
        r = '0;
        for (int k = 0; k < N; k++) begin
            idx = d[k*IB +: IB];
            r[k*OB +: OB] = tbl_ref[k*(1 << IB) + int'(idx)];
        end
        return r;
    endfunction

    // cfg_valid is deliberately high during the cfg_start cycle; that write must be dropped
    task automatic load_tbl(input int pat, input int nwr, output int ndone, output logic last_done);
        ndone = 0;
        last_done = 1'b0;
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = '1;
        step();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        for (int t = 0; t < 10 && cfg_loaded; t++) step();
        chk("load_enter", 32'(cfg_loaded), 32'd0);
        for (int i = 0; i < nwr; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = pat_val(pat, i);
            tbl_ref[i] = cfg_data;
            step();
            ndone += int'(cfg_done);
            last_done = cfg_done;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic full_load(input int pat, input string tag);
        int   nd;
        logic ld;
        load_tbl(pat, TOTAL, nd, ld);
        chk({tag, "_done_cnt"}, 32'(nd), 32'd1);
        chk({tag, "_done_last"}, 32'(ld), 32'd1);
        chk({tag, "_loaded"}, 32'(cfg_loaded), 32'd1);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        chk({tag, "_done_pulse"}, 32'(cfg_done), 32'd0);
    endtask

    // back-to-back vectors with out_ready high: 1 beat/cycle, 2-cycle latency
    task automatic run_vecs(input bit ones, input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 6);
            in_data  = (i < 6) ? vin[i] : '0;
            #1;
            if (i < 6) chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
            step();
            if (i >= 1 && i <= 6) begin
                chk({tag, "_ov"}, 32'(out_valid), 32'd1);
                chk({tag, "_od"}, 32'(out_data), ones ? 32'hF : 32'(exp_id[i-1]));
            end else begin
                chk({tag, "_ov_idle"}, 32'(out_valid), 32'd0);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int   nd;
        logic ld;
        logic stalled;
        logic [N*OB-1:0] held;

        rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < TOTAL; i++) tbl_ref[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_loaded", 32'(cfg_loaded), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_done", 32'(cfg_done), 32'd0);
        rst_n = 1'b1;
        step();

        full_load(0, "id_load");
        run_vecs(1'b0, "id_vec");

        // cfg_valid while READY must not touch the tables
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'b1; cfg_data = '1;
            step();
        end
        cfg_valid = 1'b0;
        chk("ready_cfg_loaded", 32'(cfg_loaded), 32'd1);
        run_vecs(1'b0, "ready_cfg_vec");

        // random in_valid / out_ready against a scoreboard
        stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 300; c++) begin
            if (stalled) chk("bp_stable", 32'(out_data), 32'(held));
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = (N*IB)'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("bp_extra", 32'(out_data), 32'hDEAD);
                else chk("bp_data", 32'(out_data), 32'(sb.pop_front()));
            end
            if (in_valid && in_ready) sb.push_back(ref_lookup(in_data));
            stalled = out_valid && !out_ready;
            held    = out_data;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_valid) begin
                if (sb.size() == 0) chk("bp_extra", 32'(out_data), 32'hDEAD);
                else chk("bp_data", 32'(out_data), 32'(sb.pop_front()));
            end
            step();
        end
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // reload while two beats are in flight and the output is stalled
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = vin[1];
        #1; chk("busy_acc0", 32'(in_ready), 32'd1);
        step();
        in_data = vin[5];
        #1; chk("busy_acc1", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = vin[3];
            #1;
            chk("drain_loaded", 32'(cfg_loaded), 32'd1);
            chk("drain_in_ready", 32'(in_ready), 32'd0);
            chk("drain_out", 32'(out_data), 32'hF);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("drain_mid_loaded", 32'(cfg_loaded), 32'd1);
        chk("drain_b1_valid", 32'(out_valid), 32'd1);
        chk("drain_b1_data", 32'(out_data), 32'hA);
        step();
        chk("drain_to_load", 32'(cfg_loaded), 32'd0);
        chk("drain_empty", 32'(out_valid), 32'd0);
        full_load(1, "ones_load");
        run_vecs(1'b1, "ones_vec");

        // restart mid-load: 100 zeros, then a full restart with ones
        load_tbl(2, 100, nd, ld);
        chk("restart_partial_done", 32'(nd), 32'd0);
        chk("restart_partial_loaded", 32'(cfg_loaded), 32'd0);
        full_load(1, "restart_load");
        run_vecs(1'b1, "restart_vec");

        // reset mid-load, then cfg_valid while UNLOADED, then a normal load
        load_tbl(0, 50, nd, ld);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_loaded", 32'(cfg_loaded), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_data", 32'(out_data), 32'd0);
        chk("mrst_done", 32'(cfg_done), 32'd0);
        for (int i = 0; i < TOTAL; i++) tbl_ref[i] = '0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'b1; cfg_data = '1;
            step();
            chk("unl_loaded", 32'(cfg_loaded), 32'd0);
            chk("unl_in_ready", 32'(in_ready), 32'd0);
            chk("unl_done", 32'(cfg_done), 32'd0);
        end
        cfg_valid = 1'b0;
        full_load(0, "post_rst_load");
        run_vecs(1'b0, "post_rst_vec");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/lut_layer_cfg.md
# lut_layer_cfg

Runtime-reconfigurable layer of N_NEURONS LogicNets-style LUT neurons. Each neuron maps an IN_BITS input slice to an OUT_BITS output through a truth table. Tables are loaded serially through a configuration port instead of being fixed at synthesis. Sits between quantised activation stages of the quantum-net pipeline: a 2-stage valid/ready pipeline on the data path, plus a load/drain FSM on the configuration path.

## Interface

Parameters:
- N_NEURONS, 4, number of neurons in the layer
- IN_BITS, 6, input fan-in bits per neuron (table depth 2^IN_BITS)
- OUT_BITS, 1, output bits per neuron (table entry width)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  request (re)load of all tables
- cfg_valid  in  1  cfg_data valid this cycle
- cfg_data  in  OUT_BITS  next table entry
- cfg_done  out  1  one-cycle pulse when the last entry is written
- cfg_loaded  out  1  tables valid, layer usable
- in_valid  in  1  input beat valid
- in_ready  out  1  layer accepts input beat
- in_data  in  N_NEURONS*IN_BITS  neuron k uses bits [k*IN_BITS +: IN_BITS]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output
- out_data  out  N_NEURONS*OUT_BITS  neuron k drives bits [k*OUT_BITS +: OUT_BITS]

## Operation

- Table storage: flops, TOTAL = N_NEURONS*2^IN_BITS entries of OUT_BITS. Entry address = k*2^IN_BITS + idx. idx is the unsigned value of neuron k's slice, LSB = slice bit 0.
- FSM states: UNLOADED, DRAIN, LOADING, READY.
  - UNLOADED: in_ready=0, cfg_loaded=0. cfg_start -> LOADING.
  - READY: cfg_loaded=1. cfg_start -> DRAIN.
  - DRAIN: in_ready=0, cfg_loaded=1. Moves to LOADING the first cycle both pipeline stages are empty, which includes the cycle the last beat is accepted downstream.
  - LOADING: cfg_loaded=0, in_ready=0. On entry, load address = 0. Each cycle with cfg_valid=1 writes cfg_data to table[addr] and increments addr. The write at addr=TOTAL-1 goes to READY with cfg_done=1 in that same registered cycle (visible the next cycle, for 1 cycle).
  - cfg_start in LOADING: restarts addr at 0 and stays in LOADING. If cfg_valid is asserted in the same cycle, that write is dropped.
  - cfg_start in DRAIN: no effect.
  - cfg_valid outside LOADING: ignored, no table change.
- Data path:
  - Stage 1 registers in_data on in_valid && in_ready.
  - Stage 2 registers the looked-up table entries of the stage-1 data into out_data/out_valid.
  - s2_free = !out_valid || out_ready.
  - Stage 1 advances into stage 2 when s1_valid && s2_free.
  - in_ready = (state==READY) && (!s1_valid || s2_free).
  - out_data holds stable while out_valid && !out_ready.
- Lookups use the table contents at the cycle stage 1 advances. Tables never change while either stage is occupied, guaranteed by DRAIN.

## Timing

- Reset (async assert, synchronous release):
  - state=UNLOADED, addr=0, all table entries 0.
  - s1_valid=0, out_valid=0, out_data=0, cfg_done=0, cfg_loaded=0, in_ready=0.
- Latency: beat accepted at cycle t appears on out_data/out_valid at t+2 if out_ready was high.
- Throughput: 1 beat/cycle with out_ready held high.
- Full load: TOTAL cycles of cfg_valid minimum. cfg_loaded and in_ready rise the cycle after the final write.
- Backpressure: out_ready low with both stages full forces in_ready=0 in the same cycle (combinational). No beat is lost or duplicated.
- Reset mid-load or mid-stream: all state discarded, returns to UNLOADED. A full reload is required.

## Test plan

- Identity load (N=4, IN=6, OUT=1): table[k*64+idx] = idx[k%6]. Drive 1000 random beats with out_ready=1. Required: 1 beat/cycle, latency 2, out_data matches the model for every beat.
- Backpressure: random out_ready (50%), random in_valid. Required: output sequence equals input sequence mapped through the table, no drops or repeats, out_data stable while stalled.
- Reload while busy: 2 beats in flight, cfg_start pulse, out_ready held low 5 cycles. Required: state stays DRAIN, in_ready=0, cfg_loaded=1. After both beats drain, LOADING begins. New table (all ones) gives out_data = all ones.
- Restart mid-load: write 100 entries, pulse cfg_start, then write 256 entries of 1. Required: cfg_done exactly once, after the 256th write; all lookups return 1.
- Reset mid-load and cfg_valid outside LOADING: assert rst_n=0 after 50 writes. Required: all outputs 0, cfg_loaded=0, in_ready=0. Then cfg_valid pulses while UNLOADED. Required: no table change; a subsequent full load behaves normally.
